mdu_sequencer: RTL and testbench

- E-stage multiply/divide sequencer for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E stage and holds the architectural HI/LO registers.
- Models fixed multi-cycle latency with a busy counter.
- Exports start/busy so the hazard unit stalls later MDU instructions in D.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 67 ++++++
 rtl/mdu_sequencer.sv | 117 +++++++++++
 tb/tb_mdu_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8
  } mdu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned MultLatDefault = 5;
  localparam int unsigned DivLatDefault  = 10;

  function automatic logic is_arith(input mdu_op_e op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; wr_en_o drops on divide-by-zero so HI/LO are kept.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] res_o,
  output logic        wr_en_o
);

  logic               rt_zero;
  logic               div_ovf;
  logic signed [63:0] rs_sx;
  logic signed [63:0] rt_sx;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] rs_s;
  logic signed [31:0] dv_s;
  logic        [31:0] dv_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign rt_zero = (rt_i == 32'd0);
  // Dividing by one instead of -1 yields the wrapped quotient 0x80000000 with remainder 0.
  assign div_ovf = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

  assign rs_sx  = {{32{rs_i[31]}}, rs_i};
  assign rt_sx  = {{32{rt_i[31]}}, rt_i};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

  assign rs_s  = rs_i;
  assign dv_s  = (rt_zero || div_ovf) ? 32'sd1 : rt_i;
  assign dv_u  = rt_zero ? 32'd1 : rt_i;
  assign quo_s = rs_s / dv_s;
  assign rem_s = rs_s % dv_s;
  assign quo_u = rs_i / dv_u;
  assign rem_u = rs_i % dv_u;

  always_comb begin
    res_o   = 64'd0;
    wr_en_o = 1'b0;
    case (op_i)
      OpMult: begin
        res_o   = prod_s;
        wr_en_o = 1'b1;
      end
      OpMultu: begin
        res_o   = prod_u;
        wr_en_o = 1'b1;
      end
      OpDiv: begin
        res_o   = {rem_s, quo_s};
        wr_en_o = !rt_zero;
      end
      OpDivu: begin
        res_o   = {rem_u, quo_u};
        wr_en_o = !rt_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage MDU sequencer: holds HI/LO and models fixed multiply/divide latency with a busy counter.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MultLatDefault,
  parameter int unsigned DIV_LAT  = DivLatDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic        req,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_rd
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  mdu_op_e           op;
  mdu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic              tmp_we_q, tmp_we_d;
  logic [63:0]       arith_res;
  logic              arith_we;

  assign op = mdu_op_e'(mdu_op);

  mdu_arith u_arith (
    .op_i    (op),
    .rs_i    (rs_val),
    .rt_i    (rt_val),
    .res_o   (arith_res),
    .wr_en_o (arith_we)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    tmp_we_d = tmp_we_q;
    start    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!req) begin
          if (is_arith(op)) begin
            start    = 1'b1;
            tmp_hi_d = arith_res[63:32];
            tmp_lo_d = arith_res[31:0];
            tmp_we_d = arith_we;
            cnt_d    = ((op == OpMult) || (op == OpMultu)) ? CntW'(MULT_LAT) : CntW'(DIV_LAT);
            state_d  = StRun;
          end else if (op == OpMthi) begin
            hi_d = rs_val;
          end else if (op == OpMtlo) begin
            lo_d = rs_val;
          end
        end
      end
      StRun: begin
        // Ops and flushes arriving in RUN are ignored; the in-flight result always retires.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (tmp_we_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      tmp_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      tmp_we_q <= tmp_we_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mdu_rd = 32'd0;
    if (op == OpMfhi) begin
      mdu_rd = hi_q;
    end else if (op == OpMflo) begin
      mdu_rd = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench: each accepted op queues its expected HI/LO and busy length; a monitor checks on retire.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        req;
  logic [31:0] rs, rt;
  logic        start, busy;
  logic [31:0] hi, lo, mdu_rd;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mdu_sequencer #(
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mdu_op (op),
    .req    (req),
    .rs_val (rs),
    .rt_val (rt),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .mdu_rd (mdu_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles and compare HI/LO when busy falls.
  int          busy_cnt  = 0;
  logic        busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("retire_hi", hi, e.hi);
        check("retire_lo", lo, e.lo);
        check("busy_cycles", busy_cnt, e.cyc);
      end
      busy_cnt = 0;
    end
    busy_prev = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic [31:0] ecyc);
    op = o;
    rs = a;
    rt = b;
    #1;
    check("start", {31'd0, start}, 32'd1);
    sb.push_back('{hi: ehi, lo: elo, cyc: ecyc});
    step();
    op = OpNone;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    op    = OpNone;
    req   = 1'b0;
    rs    = '0;
    rt    = '0;
    step();
    step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step();

    // MULT -2 * 3; start must not re-fire while running
    issue(OpMult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd5);
    op = OpMult;
    #1;
    check("start_in_run", {31'd0, start}, 32'd0);
    op = OpNone;
    wait_idle();
    step();

    issue(OpMultu, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 32'd5);
    wait_idle();
    step();

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd10);
    wait_idle();
    step();

    // Load HI/LO via MTHI/MTLO, then divide by zero keeps them
    op = OpMthi;
    rs = 32'h11;
    #1;
    check("mt_no_start", {31'd0, start}, 32'd0);
    step();
    check("mthi", hi, 32'h11);
    op = OpMtlo;
    rs = 32'h22;
    step();
    check("mtlo", lo, 32'h22);
    op = OpNone;
    step();
    issue(OpDivu, 32'd7, 32'd0, 32'h11, 32'h22, 32'd10);
    wait_idle();
    step();

    op = OpMthi;
    rs = 32'hDEAD_BEEF;
    step();
    check("mthi_dead", hi, 32'hDEAD_BEEF);
    op = OpMfhi;
    #1;
    check("mfhi", mdu_rd, 32'hDEAD_BEEF);
    op = OpMflo;
    #1;
    check("mflo", mdu_rd, 32'h22);
    op = OpNone;
    #1;
    check("rd_none", mdu_rd, 32'd0);
    step();

    // MTLO while busy is dropped
    issue(OpMultu, 32'd5, 32'd7, 32'd0, 32'd35, 32'd5);
    op = OpMtlo;
    rs = 32'h1234;
    step();
    op = OpNone;
    wait_idle();
    check("mtlo_ignored", lo, 32'd35);
    step();

    // Flush blocks a start
    op  = OpMult;
    rs  = 32'd2;
    rt  = 32'd2;
    req = 1'b1;
    #1;
    check("req_start", {31'd0, start}, 32'd0);
    step();
    check("req_busy", {31'd0, busy}, 32'd0);
    check("req_hi", hi, 32'd0);
    check("req_lo", lo, 32'd35);
    req = 1'b0;
    op  = OpNone;
    step();

    // Flush two cycles into a DIV does not abort it
    issue(OpDiv, 32'd100, 32'd7, 32'd2, 32'd14, 32'd10);
    step();
    req = 1'b1;
    op  = OpMult;
    step();
    req = 1'b0;
    op  = OpNone;
    wait_idle();
    step();

    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd10);
    wait_idle();
    step();

    // DIV held during MULT is ignored until the first idle cycle
    issue(OpMult, 32'd3, 32'd4, 32'd0, 32'd12, 32'd5);
    op = OpDiv;
    rs = 32'd20;
    rt = 32'd3;
    n  = 0;
    while (busy && n < 40) begin
      check("b2b_no_start", {31'd0, start}, 32'd0);
      step();
      n++;
    end
    check("b2b_start", {31'd0, start}, 32'd1);
    sb.push_back('{hi: 32'd2, lo: 32'd6, cyc: 32'd10});
    step();
    op = OpNone;
    wait_idle();
    step();

    // Reset mid-count aborts and clears
    op = OpMult;
    rs = 32'd9;
    rt = 32'd9;
    #1;
    check("start", {31'd0, start}, 32'd1);
    sb.push_back('{hi: 32'd0, lo: 32'd0, cyc: 32'd2});
    step();
    op = OpNone;
    step();
    step();
    reset = 1'b1;
    #1;
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_hi", hi, 32'd0);
    check("rst_run_lo", lo, 32'd0);
    step();
    reset = 1'b0;
    op    = OpMfhi;
    #1;
    check("mfhi_after_rst", mdu_rd, 32'd0);
    op = OpNone;

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
